serial_word_comparator: RTL and testbench
=========================================

SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

Interface
REQ-001 Parameter WIDTH, default 8: bits per compared word; WIDTH >= 1.
REQ-002 Parameter MSB_FIRST, default 1: 1 = most significant bit arrives first; 0 = least significant bit arrives first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous frame abort.
REQ-006 vld  input  1  a/b carry a valid bit pair this cycle.
REQ-007 a  input  1  current bit of operand A.
REQ-008 b  input  1  current bit of operand B.
REQ-009 res_vld  output  1  one-cycle pulse: result flags just updated.
REQ-010 a_less_b, a_eq_b, a_greater_b  output  1 each  registered result of the last completed frame.
REQ-011 busy  output  1  high while a partial frame is held (bit counter != 0).

Function
REQ-012 A frame SHALL consist of exactly WIDTH beats with vld=1; cycles with vld=0 SHALL be ignored, so gaps of any length are allowed.
REQ-013 A bit counter 0..WIDTH-1 SHALL advance on each accepted beat and wrap to 0 after beat WIDTH-1.
REQ-014 Internal running state SHALL be one of EQ, LESS, GREATER; it SHALL be EQ at frame start.
REQ-015 MSB_FIRST=1: the first beat with a!=b SHALL fix the state; later beats SHALL NOT change it.
REQ-016 MSB_FIRST=0: every beat with a!=b SHALL overwrite the state (a=0,b=1 -> LESS; a=1,b=0 -> GREATER); beats with a==b SHALL keep it.
REQ-017 On the final beat, the flags SHALL load the state including that beat one cycle later (latency 1), together with res_vld=1 for exactly that cycle.
REQ-018 Exactly one flag SHALL be high at all times; flags SHALL hold their value until the next frame completes.
REQ-019 Running state SHALL return to EQ in the same edge as the final beat, so back-to-back frames need no idle cycle.
REQ-020 clr=1 SHALL discard the partial frame (counter=0, state=EQ) without changing the flags or res_vld; when clr and vld are both high, clr SHALL win and the beat SHALL be dropped.
REQ-021 WIDTH=1 SHALL produce a result for every accepted beat.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for a clock edge, force counter=0, state=EQ, res_vld=0, a_eq_b=1, a_less_b=0, a_greater_b=0, busy=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; the first beat after release SHALL be bit 0.

Configuration
REQ-024 Macro SERIAL_CMP_SIGNED_EN defined: operands SHALL be two's complement, and the sign bit SHALL invert the decision it contributes. MSB_FIRST=1: when the first beat differs, a=1 SHALL give LESS. MSB_FIRST=0: when the final beat differs, a=1 SHALL give LESS.
REQ-025 Macro SERIAL_CMP_SIGNED_EN undefined: comparison SHALL be unsigned, and no sign logic SHALL be present.

Structure
REQ-026 Package serial_cmp_pkg SHALL hold the enum cmp_state_e (EQ, LESS, GREATER) and the flag-decode function.
REQ-027 Sub-module serial_cmp_step (combinational next-state: state, a, b, first/last, MSB_FIRST) SHALL be instantiated once.
REQ-028 Counter width SHALL be $clog2(WIDTH), minimum 1.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, continuous a=0x5A b=0x5B -> res_vld one cycle after beat 8; a_less_b=1; busy low after wrap.
REQ-030 MSB_FIRST=0, a=0x80 b=0x01 (LSB first) -> a_greater_b=1 unsigned; with SERIAL_CMP_SIGNED_EN -> a_less_b=1.
REQ-031 Frame 0xC3 vs 0xC3 with vld low 3 cycles after beat 4 -> a_eq_b=1; one res_vld, 3 cycles later than with no gap.
REQ-032 Four beats, then clr, then full frame 0x10 vs 0x20 -> single res_vld; a_less_b=1; flags unchanged at clr.
REQ-033 rst pulsed between clock edges mid-frame -> outputs reach reset values before the next edge; next frame 0xFF vs 0xFE -> a_greater_b=1.
REQ-034 Back-to-back frames 0x01/0x02, 0x02/0x01, 0x07/0x07 with no gap -> res_vld every 8 cycles; flags less, greater, eq in order.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: running comparison state type and flag decode shared by the serial comparator
//   cmp_state_e : EQ / LESS / GREATER running verdict
//   flags_of()  : state -> {a_less_b, a_eq_b, a_greater_b}, exactly one bit high
package serial_cmp_pkg;
  typedef enum logic [1:0] {EQ, LESS, GREATER} cmp_state_e;
  function automatic logic [2:0] flags_of(input cmp_state_e s);
    return {s == LESS, s == EQ, s == GREATER};
  endfunction
endpackage

// File: rtl/serial_cmp_step.sv
// serial_cmp_step: combinational next running state for one accepted bit pair
//   state in, a/b current bits, first/last beat markers, nxt out
//   MSB_FIRST=1: first differing beat decides; MSB_FIRST=0: every differing beat overwrites
//   SERIAL_CMP_SIGNED_EN: the sign beat (first when MSB first, last when LSB first) inverts its decision
module serial_cmp_step
  import serial_cmp_pkg::*;
#(
  parameter bit MSB_FIRST = 1
) (
  input  cmp_state_e state,
  input  logic       a,
  input  logic       b,
  input  logic       first,
  input  logic       last,
  output cmp_state_e nxt
);
  logic a_wins;
`ifdef SERIAL_CMP_SIGNED_EN
  assign a_wins = a ^ (MSB_FIRST ? first : last);
`else
  logic unused_pos;
  assign unused_pos = first ^ last;
  assign a_wins = a;
`endif
  cmp_state_e dec;
  assign dec = a_wins ? GREATER : LESS;
  assign nxt = (a == b || (MSB_FIRST && state != EQ)) ? state : dec;
endmodule

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: compares two WIDTH-bit words arriving one bit pair per valid beat
//   clk, rst (async, active-high), clr (sync frame abort), vld/a/b bit stream in
//   res_vld one-cycle result pulse, a_less_b/a_eq_b/a_greater_b held flags, busy partial frame held
//   SERIAL_CMP_SIGNED_EN: two's complement comparison instead of unsigned
module serial_word_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic vld,
  input  logic a,
  input  logic b,
  output logic res_vld,
  output logic a_less_b,
  output logic a_eq_b,
  output logic a_greater_b,
  output logic busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [CW-1:0] cnt;
  cmp_state_e state, nxt;
  logic first, last;
  assign first = cnt == '0;
  assign last  = cnt == CW'(WIDTH - 1);
  assign busy  = cnt != '0;
  serial_cmp_step #(.MSB_FIRST(MSB_FIRST)) u_step (
    .state(state),
    .a(a),
    .b(b),
    .first(first),
    .last(last),
    .nxt(nxt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      state <= EQ;
      res_vld <= 1'b0;
      {a_less_b, a_eq_b, a_greater_b} <= flags_of(EQ);
    end else begin
      res_vld <= 1'b0;
      if (clr) begin
        cnt <= '0;
        state <= EQ;
      end else if (vld) begin
        // final beat publishes the verdict and rearms for a back-to-back frame
        cnt <= last ? '0 : cnt + CW'(1);
        state <= last ? EQ : nxt;
        if (last) begin
          res_vld <= 1'b1;
          {a_less_b, a_eq_b, a_greater_b} <= flags_of(nxt);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator: table, corner-case and random checks of MSB-first, LSB-first and 1-bit comparators
module tb_serial_word_comparator;
  localparam logic [2:0] L3 = 3'b100, E3 = 3'b010, G3 = 3'b001;
`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SGN = 1;
`else
  localparam bit SGN = 0;
`endif
  logic clk = 0, rst = 0, clr = 0, vld = 0, a = 0, b = 0;
  logic rv_m, lt_m, eq_m, gt_m, bz_m;
  logic rv_l, lt_l, eq_l, gt_l, bz_l;
  logic rv_1, lt_1, eq_1, gt_1, bz_1;
  serial_word_comparator #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .a(a), .b(b), .res_vld(rv_m),
    .a_less_b(lt_m), .a_eq_b(eq_m), .a_greater_b(gt_m), .busy(bz_m));
  serial_word_comparator #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .a(a), .b(b), .res_vld(rv_l),
    .a_less_b(lt_l), .a_eq_b(eq_l), .a_greater_b(gt_l), .busy(bz_l));
  serial_word_comparator #(.WIDTH(1), .MSB_FIRST(1)) dut_1 (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .a(a), .b(b), .res_vld(rv_1),
    .a_less_b(lt_1), .a_eq_b(eq_1), .a_greater_b(gt_1), .busy(bz_1));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0, pulses = 0, last_pulse = 0;
  bit chk = 0;
  int k = 0;
  logic [31:0] sa = 0, sb = 0;
  logic er8 = 0, er1 = 0;
  logic [2:0] ef_m = E3, ef_l = E3, ef_1 = E3;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  // word value of a frame given the beat order; sign weight applied when signed
  function automatic longint value(input logic [31:0] s, input int n, input bit msb);
    longint v = 0;
    for (int i = 0; i < n; i++) if (s[i]) v += longint'(1) << (msb ? n - 1 - i : i);
    if (SGN && s[msb ? 0 : n - 1]) v -= longint'(1) << n;
    return v;
  endfunction
  function automatic logic [2:0] judge(input longint x, input longint y);
    return x < y ? L3 : (x > y ? G3 : E3);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; er8 = 0; er1 = 0; ef_m = E3; ef_l = E3; ef_1 = E3;
    end else begin
      er8 = 0; er1 = 0;
      if (clr) k = 0;
      else if (vld) begin
        sa[k] = a; sb[k] = b; k++;
        er1 = 1;
        ef_1 = judge(value({31'b0, a}, 1, 1), value({31'b0, b}, 1, 1));
        if (k == 8) begin
          er8 = 1;
          ef_m = judge(value(sa, 8, 1), value(sb, 8, 1));
          ef_l = judge(value(sa, 8, 0), value(sb, 8, 0));
          k = 0;
        end
      end
    end
  end
  always @(posedge clk) begin
    if (rv_m === 1'b1) begin
      pulses++;
      last_pulse = cyc;
    end
    cyc++;
  end
  always @(negedge clk) if (chk && !rst) begin
    check("res_m", {31'b0, rv_m}, {31'b0, er8});
    check("flags_m", {29'b0, lt_m, eq_m, gt_m}, {29'b0, ef_m});
    check("busy_m", {31'b0, bz_m}, {31'b0, k != 0});
    check("res_l", {31'b0, rv_l}, {31'b0, er8});
    check("flags_l", {29'b0, lt_l, eq_l, gt_l}, {29'b0, ef_l});
    check("busy_l", {31'b0, bz_l}, {31'b0, k != 0});
    check("res_1", {31'b0, rv_1}, {31'b0, er1});
    check("flags_1", {29'b0, lt_1, eq_1, gt_1}, {29'b0, ef_1});
    check("busy_1", {31'b0, bz_1}, 0);
  end
  task automatic frame(input logic [7:0] wa, input logic [7:0] wb, input int gap_at, input int gap_len, output int start);
    start = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) repeat (gap_len) begin @(negedge clk); vld = 0; end
      @(negedge clk);
      clr = 0; vld = 1; a = wa[7 - i]; b = wb[7 - i];
      if (i == 0) start = cyc;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); vld = 0; clr = 0; end
  endtask
  typedef struct {
    logic [7:0] a, b;
    logic [2:0] mu, ms, lu, ls;
  } vec_t;
  vec_t tbl[8];
  initial begin
    int st, p0;
    tbl[0] = '{8'h5A, 8'h5B, L3, L3, L3, G3};
    tbl[1] = '{8'h01, 8'h80, L3, G3, G3, L3};
    tbl[2] = '{8'hC3, 8'hC3, E3, E3, E3, E3};
    tbl[3] = '{8'h10, 8'h20, L3, L3, G3, G3};
    tbl[4] = '{8'hFF, 8'hFE, G3, G3, G3, L3};
    tbl[5] = '{8'h01, 8'h02, L3, L3, G3, L3};
    tbl[6] = '{8'h02, 8'h01, G3, G3, L3, G3};
    tbl[7] = '{8'h07, 8'h07, E3, E3, E3, E3};
    #1 rst = 1;
    #1;
    check("rst_flags_m", {29'b0, lt_m, eq_m, gt_m}, {29'b0, E3});
    check("rst_flags_l", {29'b0, lt_l, eq_l, gt_l}, {29'b0, E3});
    check("rst_res_m", {31'b0, rv_m}, 0);
    check("rst_busy_m", {31'b0, bz_m}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    chk = 1;
    for (int j = 0; j <= 8; j++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 0 && j > 0) begin
          check("tbl_res", {31'b0, rv_m}, 1);
          check("tbl_m", {29'b0, lt_m, eq_m, gt_m}, {29'b0, SGN ? tbl[j-1].ms : tbl[j-1].mu});
          check("tbl_l", {29'b0, lt_l, eq_l, gt_l}, {29'b0, SGN ? tbl[j-1].ls : tbl[j-1].lu});
        end
        if (i == 0 && j == 8) check("busy_wrap", {31'b0, bz_m}, 0);
        if (j < 8) begin vld = 1; a = tbl[j].a[7 - i]; b = tbl[j].b[7 - i]; end
        else vld = 0;
      end
    end
    frame(8'hFF, 8'hFE, 8, 0, st);
    idle(2);
    check("pre_clr", {29'b0, lt_m, eq_m, gt_m}, {29'b0, G3});
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vld = 1; a = 1'($urandom); b = 1'($urandom);
    end
    @(negedge clk);
    clr = 1; vld = 1; a = 1; b = 0;
    @(negedge clk);
    clr = 0; vld = 0;
    check("clr_flags", {29'b0, lt_m, eq_m, gt_m}, {29'b0, G3});
    check("clr_busy", {31'b0, bz_m}, 0);
    frame(8'h10, 8'h20, 8, 0, st);
    idle(2);
    check("clr_pulses", pulses - p0, 1);
    check("nogap_latency", last_pulse - st, 8);
    check("clr_result", {29'b0, lt_m, eq_m, gt_m}, {29'b0, L3});
    p0 = pulses;
    frame(8'hC3, 8'hC3, 4, 3, st);
    idle(2);
    check("gap_pulses", pulses - p0, 1);
    check("gap_latency", last_pulse - st, 11);
    check("gap_eq", {29'b0, lt_m, eq_m, gt_m}, {29'b0, E3});
    frame(8'h01, 8'h02, 8, 0, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld = 1; a = 1'($urandom); b = 1'($urandom);
    end
    @(posedge clk);
    #1;
    check("pre_rst_busy", {31'b0, bz_m}, 1);
    check("pre_rst_flags", {29'b0, lt_m, eq_m, gt_m}, {29'b0, L3});
    rst = 1; vld = 0;
    #1;
    check("async_flags", {29'b0, lt_m, eq_m, gt_m}, {29'b0, E3});
    check("async_res", {31'b0, rv_m}, 0);
    check("async_busy", {31'b0, bz_m}, 0);
    #1 rst = 0;
    frame(8'hFF, 8'hFE, 8, 0, st);
    idle(2);
    check("post_rst", {29'b0, lt_m, eq_m, gt_m}, {29'b0, G3});
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      vld = ($urandom % 4) != 0;
      a = 1'($urandom);
      b = ($urandom % 3 == 0) ? 1'($urandom) : a;
      clr = ($urandom % 50) == 0;
    end
    idle(3);
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
